// File: rtl/fork_arbiter.sv
// Ring fork arbiter (dining philosophers). Each requester needs its own fork and
// the fork to its right. Selection is round-robin, and a starving waiter blocks its neighbours.
module fork_arbiter #(
    parameter int N       = 8,
    parameter int MAXWAIT = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N-1:0]           req,
    output logic [N-1:0]           gnt,
    output logic [N-1:0]           fork_busy,
    output logic [N-1:0]           starve,
    output logic [$clog2(N+1)-1:0] eating_cnt
);
    localparam int PW = $clog2(N);
    localparam int CW = $clog2(MAXWAIT + 1);
    localparam int EW = $clog2(N + 1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_EAT = 2'd2} state_t;

    state_t        r_state      [N];
    state_t        w_state_next [N];
    logic [CW-1:0] r_cnt        [N];
    logic [CW-1:0] w_cnt_next   [N];
    logic [PW-1:0] r_ptr, w_ptr_next;
    logic [N-1:0]  r_gnt, r_busy, r_starve;
    logic [EW-1:0] r_eat_cnt, w_eat_cnt_next;
    logic [N-1:0]  w_eat, w_wait, w_fbusy, w_blocked, w_cand, w_sel;
    logic [N-1:0]  w_eat_next, w_busy_next, w_starve_next;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_ring
            localparam int LEFT  = (gi + N - 1) % N;
            localparam int RIGHT = (gi + 1) % N;
            assign w_eat[gi]       = (r_state[gi] == ST_EAT);
            assign w_wait[gi]      = (r_state[gi] == ST_WAIT);
            assign w_fbusy[gi]     = w_eat[gi] | w_eat[LEFT];
            assign w_blocked[gi]   = !r_starve[gi] &&
                                     ((w_wait[LEFT] && r_starve[LEFT]) ||
                                      (w_wait[RIGHT] && r_starve[RIGHT]));
            // A waiter still holding req, not blocked, with both forks idle.
            assign w_cand[gi]      = w_wait[gi] & req[gi] & ~w_blocked[gi] &
                                     ~w_fbusy[gi] & ~w_fbusy[RIGHT];
            assign w_eat_next[gi]  = (w_state_next[gi] == ST_EAT);
            assign w_busy_next[gi] = w_eat_next[gi] | w_eat_next[LEFT];
        end
    endgenerate

    // Round-robin scan from r_ptr; forks claimed earlier in the scan are unavailable.
    always_comb begin
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        logic [PW-1:0] nxt;
        logic [N-1:0]  claim;
        sum        = '0;
        idx        = '0;
        nxt        = '0;
        claim      = '0;
        w_sel      = '0;
        w_ptr_next = r_ptr;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, r_ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N))
                sum = sum - (PW+1)'(N);
            idx = sum[PW-1:0];
            nxt = (idx == PW'(N - 1)) ? '0 : idx + PW'(1);
            if (w_cand[idx] && !claim[idx] && !claim[nxt]) begin
                w_sel[idx] = 1'b1;
                claim[idx] = 1'b1;
                claim[nxt] = 1'b1;
                w_ptr_next = nxt;
            end
        end
    end

    always_comb begin
        w_eat_cnt_next = '0;
        w_starve_next  = '0;
        for (int i = 0; i < N; i++) begin
            w_state_next[i] = r_state[i];
            case (r_state[i])
                ST_IDLE: if (req[i]) w_state_next[i] = ST_WAIT;
                ST_WAIT: begin
                    if (!req[i])
                        w_state_next[i] = ST_IDLE;
                    else if (w_sel[i])
                        w_state_next[i] = ST_EAT;
                end
                ST_EAT:  if (!req[i]) w_state_next[i] = ST_IDLE;
                default: w_state_next[i] = ST_IDLE;
            endcase
            if (r_state[i] == ST_WAIT && w_state_next[i] == ST_WAIT)
                w_cnt_next[i] = (r_cnt[i] == CW'(MAXWAIT)) ? r_cnt[i] : r_cnt[i] + CW'(1);
            else
                w_cnt_next[i] = '0;
            w_starve_next[i] = (w_state_next[i] == ST_WAIT) && (w_cnt_next[i] == CW'(MAXWAIT));
            if (w_state_next[i] == ST_EAT)
                w_eat_cnt_next = w_eat_cnt_next + EW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                r_state[i] <= ST_IDLE;
                r_cnt[i]   <= '0;
            end
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_busy    <= '0;
            r_starve  <= '0;
            r_eat_cnt <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                r_state[i] <= w_state_next[i];
                r_cnt[i]   <= w_cnt_next[i];
            end
            r_ptr     <= w_ptr_next;
            r_gnt     <= w_eat_next;
            r_busy    <= w_busy_next;
            r_starve  <= w_starve_next;
            r_eat_cnt <= w_eat_cnt_next;
        end
    end

    assign gnt        = r_gnt;
    assign fork_busy  = r_busy;
    assign starve     = r_starve;
    assign eating_cnt = r_eat_cnt;
endmodule
